vga_layer_sequencer: RTL

//  Parametrised multi-layer frame compositor for the 160x120 VGA adaptor path.
//  On start it scans NUM_LAYERS rectangular layers in order (0 = background, highest = topmost).
//  For each layer it issues one ROM address per cycle and emits x/y/colour/write_en pixel writes.
//  Off-screen pixels are clipped; key-colour pixels are optionally masked.

---
 rtl/vga_layer_sequencer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_layer_sequencer.sv
// Multi-layer frame compositor: scans layer rectangles into x/y/colour pixel writes.
// Optional colour keying of layers above 0 is enabled by defining VGA_SEQ_COLOUR_KEY_EN.
module vga_layer_sequencer #(
  parameter int NUM_LAYERS   = 4,
  parameter int LAYER_IDX_W  = 2,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int COLOUR_WIDTH = 8,
  parameter int ADDR_WIDTH   = 15,
  parameter logic [COLOUR_WIDTH-1:0] KEY_COLOUR = 8'h09
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_LAYERS-1:0]            layer_en,
  input  logic [NUM_LAYERS*X_WIDTH-1:0]    layer_x,
  input  logic [NUM_LAYERS*Y_WIDTH-1:0]    layer_y,
  input  logic [NUM_LAYERS*X_WIDTH-1:0]    layer_w,
  input  logic [NUM_LAYERS*Y_WIDTH-1:0]    layer_h,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_base,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [COLOUR_WIDTH-1:0]          rom_data,
  output logic [X_WIDTH-1:0]               x,
  output logic [Y_WIDTH-1:0]               y,
  output logic [COLOUR_WIDTH-1:0]          colour,
  output logic                             write_en,
  output logic [LAYER_IDX_W-1:0]           layer,
  output logic                             busy,
  output logic                             done
);

`ifdef VGA_SEQ_COLOUR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LAYER_IDX_W-1:0]           lidx_q, lidx_d;
  logic [NUM_LAYERS-1:0]            en_q, en_d;
  logic [NUM_LAYERS*X_WIDTH-1:0]    lx_q, lx_d, lw_q, lw_d;
  logic [NUM_LAYERS*Y_WIDTH-1:0]    ly_q, ly_d, lh_q, lh_d;
  logic [NUM_LAYERS*ADDR_WIDTH-1:0] lb_q, lb_d;
  logic [X_WIDTH-1:0]               col_q, col_d;
  logic [Y_WIDTH-1:0]               row_q, row_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic                             drain_q, drain_d;

  logic                             v2_q, v2_d, clip2_q, clip2_d;
  logic [X_WIDTH-1:0]               x2_q, x2_d;
  logic [Y_WIDTH-1:0]               y2_q, y2_d;
  logic [LAYER_IDX_W-1:0]           l2_q, l2_d;

  logic [X_WIDTH-1:0]               x_q, x_d;
  logic [Y_WIDTH-1:0]               y_q, y_d;
  logic [COLOUR_WIDTH-1:0]          colour_q, colour_d;
  logic                             we_q, we_d;
  logic [LAYER_IDX_W-1:0]           layer_q, layer_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic                  cur_en, skip, last_layer, last_col, last_pix, key_hit;
  logic [X_WIDTH-1:0]    cur_x, cur_w;
  logic [Y_WIDTH-1:0]    cur_y, cur_h;
  logic [ADDR_WIDTH-1:0] cur_b;
  logic [X_WIDTH:0]      sx;
  logic [Y_WIDTH:0]      sy;

  always_comb begin
    cur_en     = en_q[lidx_q];
    cur_x      = lx_q[int'(lidx_q)*X_WIDTH +: X_WIDTH];
    cur_w      = lw_q[int'(lidx_q)*X_WIDTH +: X_WIDTH];
    cur_y      = ly_q[int'(lidx_q)*Y_WIDTH +: Y_WIDTH];
    cur_h      = lh_q[int'(lidx_q)*Y_WIDTH +: Y_WIDTH];
    cur_b      = lb_q[int'(lidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
    skip       = !cur_en || (cur_w == '0) || (cur_h == '0);
    last_layer = (lidx_q == LAYER_IDX_W'(NUM_LAYERS - 1));
    last_col   = (col_q == cur_w - X_WIDTH'(1));
    last_pix   = last_col && (row_q == cur_h - Y_WIDTH'(1));
    // one extra bit so a wrap past the coordinate width still clips
    sx         = {1'b0, cur_x} + {1'b0, col_q};
    sy         = {1'b0, cur_y} + {1'b0, row_q};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (!skip)          state_d = S_SCAN;
        else if (last_layer) state_d = S_DRAIN;
      end
      S_SCAN:  if (last_pix) state_d = last_layer ? S_DRAIN : S_LOAD;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lidx_d  = lidx_q;
    en_d    = en_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    lw_d    = lw_q;
    lh_d    = lh_q;
    lb_d    = lb_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    drain_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d   = layer_en;
          lx_d   = layer_x;
          ly_d   = layer_y;
          lw_d   = layer_w;
          lh_d   = layer_h;
          lb_d   = layer_base;
          lidx_d = '0;
        end
      end
      S_LOAD: begin
        if (skip) begin
          if (!last_layer) lidx_d = lidx_q + LAYER_IDX_W'(1);
        end else begin
          col_d  = '0;
          row_d  = '0;
          addr_d = cur_b;
        end
      end
      S_SCAN: begin
        if (last_pix) begin
          if (!last_layer) lidx_d = lidx_q + LAYER_IDX_W'(1);
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (last_col) begin
            col_d = '0;
            row_d = row_q + Y_WIDTH'(1);
          end else begin
            col_d = col_q + X_WIDTH'(1);
          end
        end
      end
      S_DRAIN: drain_d = 1'b1;
      default: ;
    endcase
  end

  // addr_q is the ROM address of the pixel being scanned this cycle
  always_comb begin
    v2_d     = (state_q == S_SCAN);
    x2_d     = sx[X_WIDTH-1:0];
    y2_d     = sy[Y_WIDTH-1:0];
    clip2_d  = (sx >= (X_WIDTH+1)'(SCREEN_W)) || (sy >= (Y_WIDTH+1)'(SCREEN_H));
    l2_d     = lidx_q;
    key_hit  = KEY_EN && (l2_q != '0) && (rom_data == KEY_COLOUR);
    we_d     = v2_q && !clip2_q && !key_hit;
    x_d      = x2_q;
    y_d      = y2_q;
    colour_d = rom_data;
    layer_d  = l2_q;
    busy_d   = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_DRAIN);
    done_d   = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lidx_q   <= '0;
      en_q     <= '0;
      lx_q     <= '0;
      ly_q     <= '0;
      lw_q     <= '0;
      lh_q     <= '0;
      lb_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      drain_q  <= 1'b0;
      v2_q     <= 1'b0;
      clip2_q  <= 1'b0;
      x2_q     <= '0;
      y2_q     <= '0;
      l2_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
      layer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      lidx_q   <= lidx_d;
      en_q     <= en_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      lw_q     <= lw_d;
      lh_q     <= lh_d;
      lb_q     <= lb_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      v2_q     <= v2_d;
      clip2_q  <= clip2_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      l2_q     <= l2_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
      layer_q  <= layer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign write_en = we_q;
  assign layer    = layer_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
